// File: rtl/stg4mo.sv
// Memory/writeback pipeline stage: non-memory instructions pass straight to the writeback latch,
// loads/stores run a stalled request/ack handshake. Optional macro MEM_TIMEOUT_EN adds a 256-cycle ack timeout.
module stg4mo #(
   parameter int                  SIZE_ADDR   = 24,
   parameter int                  SIZE_DATA   = 24,
   parameter int                  SIZE_OPC    = 6,
   parameter int                  SIZE_TGT_GP = 5,
   parameter int                  SIZE_TGT_SR = 3,
   parameter int                  HBIT_ADDR   = SIZE_ADDR - 1,
   parameter logic [SIZE_OPC-1:0] OPC_M_LD    = 6'h10,
   parameter logic [SIZE_OPC-1:0] OPC_M_ST    = 6'h11
) (
   input  logic                   iw_clk,
   input  logic                   iw_rst,
   input  logic [SIZE_ADDR-1:0]   iw_pc,
   input  logic [SIZE_DATA-1:0]   iw_instr,
   input  logic [SIZE_OPC-1:0]    iw_opc,
   input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
   input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
   input  logic [SIZE_DATA-1:0]   iw_result,
   input  logic [SIZE_DATA-1:0]   iw_st_data,
   output logic                   ow_stall,
   output logic                   ow_mem_req,
   output logic                   ow_mem_we,
   output logic [SIZE_ADDR-1:0]   ow_mem_addr,
   output logic [SIZE_DATA-1:0]   ow_mem_wdata,
   input  logic                   iw_mem_ack,
   input  logic [SIZE_DATA-1:0]   iw_mem_rdata,
   output logic [SIZE_ADDR-1:0]   ow_pc,
   output logic [SIZE_DATA-1:0]   ow_instr,
   output logic [SIZE_OPC-1:0]    ow_opc,
   output logic [SIZE_TGT_GP-1:0] ow_tgt_gp,
   output logic [SIZE_TGT_SR-1:0] ow_tgt_sr,
   output logic [SIZE_DATA-1:0]   ow_result,
   output logic                   ow_fault
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t                 r_state;
   logic                   r_mem_req;
   logic                   r_mem_we;
   logic [SIZE_ADDR-1:0]   r_mem_addr;
   logic [SIZE_DATA-1:0]   r_mem_wdata;
   logic [SIZE_ADDR-1:0]   r_pc;
   logic [SIZE_DATA-1:0]   r_instr;
   logic [SIZE_OPC-1:0]    r_opc;
   logic [SIZE_TGT_GP-1:0] r_tgt_gp;
   logic [SIZE_TGT_SR-1:0] r_tgt_sr;
   logic [SIZE_DATA-1:0]   r_result;

   logic                   w_is_st;
   logic                   w_is_mem;
   logic                   w_timeout;
   logic                   w_stall;
   logic [SIZE_DATA-1:0]   w_wb_result;

   assign w_is_st  = (iw_opc == OPC_M_ST);
   assign w_is_mem = (iw_opc == OPC_M_LD) || w_is_st;

`ifdef MEM_TIMEOUT_EN
   logic [7:0] r_wait_cnt;
   logic       r_fault;
   assign w_timeout = (r_state == S_BUSY) && (r_wait_cnt == 8'hFF) && !iw_mem_ack;
   assign ow_fault  = r_fault;
`else
   assign w_timeout = 1'b0;
   assign ow_fault  = 1'b0;
`endif

   // Stall decision and the value written back when the latch is not loading a bubble
   always_comb begin
      w_stall     = 1'b0;
      w_wb_result = {SIZE_DATA{1'b0}};
      case (r_state)
         S_IDLE: begin
            w_stall     = w_is_mem;
            w_wb_result = iw_result;
         end
         S_BUSY: begin
            w_stall = !iw_mem_ack && !w_timeout;
            if (iw_mem_ack && !r_mem_we) begin
               w_wb_result = iw_mem_rdata;
            end else begin
               w_wb_result = {SIZE_DATA{1'b0}};
            end
         end
         default: begin
            w_stall     = 1'b0;
            w_wb_result = {SIZE_DATA{1'b0}};
         end
      endcase
   end

   // FSM, memory request registers and writeback latch
   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         r_state     <= S_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= {SIZE_ADDR{1'b0}};
         r_mem_wdata <= {SIZE_DATA{1'b0}};
         r_pc        <= {SIZE_ADDR{1'b0}};
         r_instr     <= {SIZE_DATA{1'b0}};
         r_opc       <= {SIZE_OPC{1'b0}};
         r_tgt_gp    <= {SIZE_TGT_GP{1'b0}};
         r_tgt_sr    <= {SIZE_TGT_SR{1'b0}};
         r_result    <= {SIZE_DATA{1'b0}};
`ifdef MEM_TIMEOUT_EN
         r_wait_cnt  <= 8'h00;
         r_fault     <= 1'b0;
`endif
      end else begin
`ifdef MEM_TIMEOUT_EN
         r_fault <= 1'b0;
`endif
         // A stalled edge always writes a NOP bubble
         if (w_stall) begin
            r_pc     <= {SIZE_ADDR{1'b0}};
            r_instr  <= {SIZE_DATA{1'b0}};
            r_opc    <= {SIZE_OPC{1'b0}};
            r_tgt_gp <= {SIZE_TGT_GP{1'b0}};
            r_tgt_sr <= {SIZE_TGT_SR{1'b0}};
            r_result <= {SIZE_DATA{1'b0}};
         end else begin
            r_pc     <= iw_pc;
            r_instr  <= iw_instr;
            r_opc    <= iw_opc;
            r_tgt_gp <= iw_tgt_gp;
            r_tgt_sr <= iw_tgt_sr;
            r_result <= w_wb_result;
         end
         case (r_state)
            S_IDLE: begin
               if (w_is_mem) begin
                  r_state     <= S_BUSY;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= w_is_st;
                  r_mem_addr  <= iw_result[HBIT_ADDR:0];
                  r_mem_wdata <= w_is_st ? iw_st_data : {SIZE_DATA{1'b0}};
`ifdef MEM_TIMEOUT_EN
                  r_wait_cnt  <= 8'h00;
`endif
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_BUSY: begin
               if (iw_mem_ack || w_timeout) begin
                  r_state   <= S_IDLE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                  r_fault   <= w_timeout;
`endif
               end else begin
                  r_state <= S_BUSY;
`ifdef MEM_TIMEOUT_EN
                  r_wait_cnt <= r_wait_cnt + 8'h01;
`endif
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_mem_req <= 1'b0;
               r_mem_we  <= 1'b0;
            end
         endcase
      end
   end

   assign ow_stall     = w_stall;
   assign ow_mem_req   = r_mem_req;
   assign ow_mem_we    = r_mem_we;
   assign ow_mem_addr  = r_mem_addr;
   assign ow_mem_wdata = r_mem_wdata;
   assign ow_pc        = r_pc;
   assign ow_instr     = r_instr;
   assign ow_opc       = r_opc;
   assign ow_tgt_gp    = r_tgt_gp;
   assign ow_tgt_sr    = r_tgt_sr;
   assign ow_result    = r_result;

endmodule

// File: tb/tb_stg4mo.sv
// Scoreboard bench for stg4mo: stimulus pushes expected writeback entries, a negedge monitor
// pops one whenever a non-NOP instruction appears in the writeback latch.
module tb_stg4mo;
   localparam logic [5:0] OPC_NOP = 6'h00;
   localparam logic [5:0] OPC_ADD = 6'h01;
   localparam logic [5:0] OPC_SUB = 6'h02;
   localparam logic [5:0] OPC_LD  = 6'h10;
   localparam logic [5:0] OPC_ST  = 6'h11;

   typedef struct packed {
      logic [23:0] pc;
      logic [23:0] instr;
      logic [5:0]  opc;
      logic [4:0]  gp;
      logic [2:0]  sr;
      logic [23:0] res;
      logic        fault;
   } wb_t;

   logic        iw_clk = 1'b0;
   logic        iw_rst;
   logic [23:0] iw_pc, iw_instr, iw_result, iw_st_data, iw_mem_rdata;
   logic [5:0]  iw_opc;
   logic [4:0]  iw_tgt_gp;
   logic [2:0]  iw_tgt_sr;
   logic        iw_mem_ack;
   logic        ow_stall, ow_mem_req, ow_mem_we, ow_fault;
   logic [23:0] ow_mem_addr, ow_mem_wdata, ow_pc, ow_instr, ow_result;
   logic [5:0]  ow_opc;
   logic [4:0]  ow_tgt_gp;
   logic [2:0]  ow_tgt_sr;

   int  n_checks = 0;
   int  n_pass   = 0;
   wb_t exp_q[$];

   stg4mo dut (
      .iw_clk(iw_clk), .iw_rst(iw_rst),
      .iw_pc(iw_pc), .iw_instr(iw_instr), .iw_opc(iw_opc),
      .iw_tgt_gp(iw_tgt_gp), .iw_tgt_sr(iw_tgt_sr),
      .iw_result(iw_result), .iw_st_data(iw_st_data),
      .ow_stall(ow_stall), .ow_mem_req(ow_mem_req), .ow_mem_we(ow_mem_we),
      .ow_mem_addr(ow_mem_addr), .ow_mem_wdata(ow_mem_wdata),
      .iw_mem_ack(iw_mem_ack), .iw_mem_rdata(iw_mem_rdata),
      .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_opc(ow_opc),
      .ow_tgt_gp(ow_tgt_gp), .ow_tgt_sr(ow_tgt_sr),
      .ow_result(ow_result), .ow_fault(ow_fault)
   );

   always #5 iw_clk = ~iw_clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic drive(input logic [23:0] pc, input logic [23:0] instr, input logic [5:0] opc,
                        input logic [4:0] gp, input logic [2:0] sr,
                        input logic [23:0] res, input logic [23:0] st);
      iw_pc = pc; iw_instr = instr; iw_opc = opc; iw_tgt_gp = gp;
      iw_tgt_sr = sr; iw_result = res; iw_st_data = st;
   endtask

   task automatic nop();
      drive(24'h0, 24'h0, OPC_NOP, 5'd0, 3'd0, 24'h0, 24'h0);
   endtask

   function automatic wb_t mk(input logic [23:0] pc, input logic [23:0] instr, input logic [5:0] opc,
                              input logic [4:0] gp, input logic [2:0] sr,
                              input logic [23:0] res, input logic fault);
      mk = '{pc: pc, instr: instr, opc: opc, gp: gp, sr: sr, res: res, fault: fault};
   endfunction

   // Monitor: every non-NOP writeback entry must match the oldest expected entry
   always @(negedge iw_clk) begin
      wb_t act;
      act = '{pc: ow_pc, instr: ow_instr, opc: ow_opc, gp: ow_tgt_gp, sr: ow_tgt_sr,
              res: ow_result, fault: ow_fault};
      if (!iw_rst && ow_opc != OPC_NOP) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL wb_unexpected: actual=%0h required=none", act);
         end else begin
            chk("wb_entry", {41'h0, act}, {41'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_stall;
      iw_rst = 1'b1; iw_mem_ack = 1'b0; iw_mem_rdata = 24'h0;
      nop();
      repeat (2) @(negedge iw_clk);
      chk("rst_req",   {127'h0, ow_mem_req}, 128'h0);
      chk("rst_we",    {127'h0, ow_mem_we},  128'h0);
      chk("rst_addr",  {104'h0, ow_mem_addr}, 128'h0);
      chk("rst_wb",    {41'h0, ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_sr, ow_result, ow_fault}, 128'h0);
      iw_rst = 1'b0;

      // ADD pass-through, 1-cycle latency, never stalls
      @(negedge iw_clk);
      drive(24'h000010, 24'h00A001, OPC_ADD, 5'd3, 3'd1, 24'h00ABCD, 24'h0);
      exp_q.push_back(mk(24'h000010, 24'h00A001, OPC_ADD, 5'd3, 3'd1, 24'h00ABCD, 1'b0));
      #1 chk("add_stall", {127'h0, ow_stall}, 128'h0);
      @(negedge iw_clk);
      nop();
      chk("add_no_req", {127'h0, ow_mem_req}, 128'h0);

      // LD 0x100, ack after 3 busy cycles
      @(negedge iw_clk);
      drive(24'h000020, 24'h00B002, OPC_LD, 5'd4, 3'd2, 24'h000100, 24'h0);
      exp_q.push_back(mk(24'h000020, 24'h00B002, OPC_LD, 5'd4, 3'd2, 24'h123456, 1'b0));
      #1 chk("ld_idle_stall", {127'h0, ow_stall}, 128'h1);
      for (int i = 0; i < 3; i++) begin
         @(negedge iw_clk);
         chk("ld_req",   {127'h0, ow_mem_req}, 128'h1);
         chk("ld_we",    {127'h0, ow_mem_we},  128'h0);
         chk("ld_addr",  {104'h0, ow_mem_addr}, 128'h000100);
         chk("ld_wdata", {104'h0, ow_mem_wdata}, 128'h0);
         if (i == 2) begin
            iw_mem_ack = 1'b1; iw_mem_rdata = 24'h123456;
            #1 chk("ld_ack_stall", {127'h0, ow_stall}, 128'h0);
         end else begin
            #1 chk("ld_busy_stall", {127'h0, ow_stall}, 128'h1);
         end
      end
      @(negedge iw_clk);
      iw_mem_ack = 1'b0; nop();
      chk("ld_done_req", {127'h0, ow_mem_req}, 128'h0);

      // ST 0x200 with immediate ack, then back-to-back LD 0x300
      @(negedge iw_clk);
      drive(24'h000030, 24'h00C003, OPC_ST, 5'd0, 3'd0, 24'h000200, 24'h00BEEF);
      exp_q.push_back(mk(24'h000030, 24'h00C003, OPC_ST, 5'd0, 3'd0, 24'h000000, 1'b0));
      #1 chk("st_idle_stall", {127'h0, ow_stall}, 128'h1);
      @(negedge iw_clk);
      chk("st_req",   {127'h0, ow_mem_req}, 128'h1);
      chk("st_we",    {127'h0, ow_mem_we},  128'h1);
      chk("st_addr",  {104'h0, ow_mem_addr}, 128'h000200);
      chk("st_wdata", {104'h0, ow_mem_wdata}, 128'h00BEEF);
      iw_mem_ack = 1'b1; iw_mem_rdata = 24'h777777;
      #1 chk("st_ack_stall", {127'h0, ow_stall}, 128'h0);
      @(negedge iw_clk);
      iw_mem_ack = 1'b0;
      chk("st_done_req", {127'h0, ow_mem_req}, 128'h0);
      chk("st_done_we",  {127'h0, ow_mem_we},  128'h0);
      drive(24'h000040, 24'h00D004, OPC_LD, 5'd7, 3'd3, 24'h000300, 24'h0);
      exp_q.push_back(mk(24'h000040, 24'h00D004, OPC_LD, 5'd7, 3'd3, 24'h0A0B0C, 1'b0));
      #1 chk("b2b_stall", {127'h0, ow_stall}, 128'h1);
      @(negedge iw_clk);
      chk("b2b_req",  {127'h0, ow_mem_req}, 128'h1);
      chk("b2b_addr", {104'h0, ow_mem_addr}, 128'h000300);
      iw_mem_ack = 1'b1; iw_mem_rdata = 24'h0A0B0C;
      @(negedge iw_clk);
      iw_mem_ack = 1'b0; nop();
      chk("b2b_done_req", {127'h0, ow_mem_req}, 128'h0);

      // ack while IDLE with a non-memory opcode
      @(negedge iw_clk);
      drive(24'h000050, 24'h00E005, OPC_SUB, 5'd9, 3'd5, 24'h000055, 24'h0);
      iw_mem_ack = 1'b1; iw_mem_rdata = 24'h999999;
      exp_q.push_back(mk(24'h000050, 24'h00E005, OPC_SUB, 5'd9, 3'd5, 24'h000055, 1'b0));
      #1 chk("idle_ack_stall", {127'h0, ow_stall}, 128'h0);
      @(negedge iw_clk);
      iw_mem_ack = 1'b0; nop();
      chk("idle_ack_req", {127'h0, ow_mem_req}, 128'h0);

      // Reset in the 2nd busy cycle of a LD, late ack afterwards
      @(negedge iw_clk);
      drive(24'h000060, 24'h00F006, OPC_LD, 5'd1, 3'd1, 24'h000400, 24'h0);
      @(negedge iw_clk);
      chk("rbusy_req", {127'h0, ow_mem_req}, 128'h1);
      @(negedge iw_clk);
      iw_rst = 1'b1;
      @(negedge iw_clk);
      iw_rst = 1'b0; nop();
      iw_mem_ack = 1'b1; iw_mem_rdata = 24'h999999;
      chk("rbusy_req_clr", {127'h0, ow_mem_req}, 128'h0);
      chk("rbusy_mem", {79'h0, ow_mem_we, ow_mem_addr, ow_mem_wdata}, 128'h0);
      chk("rbusy_wb",  {41'h0, ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_sr, ow_result, ow_fault}, 128'h0);
      #1 chk("rbusy_ack_stall", {127'h0, ow_stall}, 128'h0);
      @(negedge iw_clk);
      iw_mem_ack = 1'b0;
      chk("rbusy_late_ack", {79'h0, ow_mem_req, ow_mem_addr, ow_result}, 128'h0);

`ifdef MEM_TIMEOUT_EN
      // LD with no ack: 256 stall cycles, one-cycle fault, then normal op
      @(negedge iw_clk);
      drive(24'h000070, 24'h00A007, OPC_LD, 5'd2, 3'd2, 24'h000500, 24'h0);
      exp_q.push_back(mk(24'h000070, 24'h00A007, OPC_LD, 5'd2, 3'd2, 24'h000000, 1'b1));
      n_stall = 0;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (!ow_stall) break;
         n_stall++;
         @(negedge iw_clk);
      end
      chk("to_stall_cycles", 128'(n_stall), 128'd256);
      @(negedge iw_clk);
      nop();
      chk("to_fault", {127'h0, ow_fault}, 128'h1);
      @(negedge iw_clk);
      chk("to_fault_once", {127'h0, ow_fault}, 128'h0);
      drive(24'h000080, 24'h00B008, OPC_ADD, 5'd6, 3'd4, 24'h000ABC, 24'h0);
      exp_q.push_back(mk(24'h000080, 24'h00B008, OPC_ADD, 5'd6, 3'd4, 24'h000ABC, 1'b0));
      #1 chk("to_next_stall", {127'h0, ow_stall}, 128'h0);
      @(negedge iw_clk);
      nop();
`else
      n_stall = 0;
`endif

      repeat (3) @(negedge iw_clk);
      chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
